west_feeder: RTL

West-edge driver for one row of MAC tiles. It buffers incoming weight and activation words in a small FIFO, then issues them on the row's west input with the tile instruction encoding: bit0 = kernel load, bit1 = execute. It sequences the weight-load and execute phases and inserts drain cycles so that "done" means the row has quiesced. One instance sits per array row, between the L0/SRAM side and tile column 0.

---
 rtl/west_feeder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/west_feeder.sv
// west_feeder: west-edge issue logic for one MAC-tile row (word FIFO + load/exec sequencer).
// Defining WEST_FEEDER_STALL_CNT_EN adds the saturating stall_cnt output.
module west_feeder #(
  parameter int bw     = 4,
  parameter int col    = 8,
  parameter int depth  = 16,
  parameter int len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [bw-1:0]     in,
  input  logic              wr,
  output logic              full,
  output logic              empty,
  input  logic              cmd_load,
  input  logic              cmd_exec,
  input  logic [len_bw-1:0] exec_len,
  output logic [bw-1:0]     out_e,
  output logic [1:0]        inst_e,
  output logic              busy,
  output logic              done,
  output logic              kernel_loaded,
`ifdef WEST_FEEDER_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
  output logic              err
`else
  output logic              err
`endif
);

  // state   | meaning
  // IDLE    | waiting for cmd_load / cmd_exec
  // LOAD    | issuing col weights (inst 01)
  // EXEC    | issuing exec_len activations (inst 10)
  // DRAIN   | col cycles of inst 00 so the row quiesces before done

  localparam int AW = $clog2(depth);
  localparam int CW = (len_bw > $clog2(col + 1)) ? len_bw : $clog2(col + 1);
  localparam logic [CW-1:0] COL_C = CW'(col);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DRAIN} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc, w_len_ext;
  logic [len_bw-1:0]   r_len, w_len_nxt;
  logic                r_was_load, w_was_load_nxt;
  logic [bw-1:0]       r_mem [depth];
  logic [AW:0]         r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
  logic                r_full, r_empty;
  logic [bw-1:0]       r_out_e;
  logic [1:0]          r_inst_e;
  logic                r_done, r_kl, r_err;
  logic                w_push, w_pop;
  logic                w_done_nxt, w_kl_set, w_err_set;

  assign w_push     = wr & ~r_full;
  assign w_pop      = ((r_state == S_LOAD) || (r_state == S_EXEC)) && !r_empty;
  assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_len_ext  = CW'(r_len);

  // Storage carries no reset; flushing is done by clearing the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                 (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
      r_empty <= (w_wptr_nxt == w_rptr_nxt);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_len_nxt      = r_len;
    w_was_load_nxt = r_was_load;
    w_done_nxt     = 1'b0;
    w_kl_set       = 1'b0;
    w_err_set      = wr & r_full;
    case (r_state)
      S_IDLE: begin
        if (cmd_load) begin
          if (cmd_exec) w_err_set = 1'b1;
          if (r_kl) begin
            w_err_set = 1'b1;
          end else begin
            w_state_nxt    = S_LOAD;
            w_cnt_nxt      = '0;
            w_was_load_nxt = 1'b1;
          end
        end else if (cmd_exec) begin
          w_cnt_nxt      = '0;
          w_len_nxt      = exec_len;
          w_was_load_nxt = 1'b0;
          if (exec_len == '0) w_done_nxt  = 1'b1;
          else                w_state_nxt = S_EXEC;
        end
      end
      S_LOAD: begin
        if (cmd_load || cmd_exec) w_err_set = 1'b1;
        if (w_pop) begin
          if (w_cnt_inc == COL_C) begin
            w_state_nxt = S_DRAIN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_EXEC: begin
        if (cmd_load || cmd_exec) w_err_set = 1'b1;
        if (w_pop) begin
          if (w_cnt_inc == w_len_ext) begin
            w_state_nxt = S_DRAIN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_DRAIN: begin
        if (cmd_load || cmd_exec) w_err_set = 1'b1;
        if (w_cnt_inc == COL_C) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_kl_set    = r_was_load;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_was_load <= 1'b0;
      r_out_e    <= '0;
      r_inst_e   <= 2'b00;
      r_done     <= 1'b0;
      r_kl       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_len      <= w_len_nxt;
      r_was_load <= w_was_load_nxt;
      r_done     <= w_done_nxt;
      if (w_kl_set)  r_kl  <= 1'b1;
      if (w_err_set) r_err <= 1'b1;
      // out_e only moves on an issued word; bubbles keep the last value
      if (w_pop) begin
        r_out_e  <= r_mem[r_rptr[AW-1:0]];
        r_inst_e <= (r_state == S_LOAD) ? 2'b01 : 2'b10;
      end else begin
        r_inst_e <= 2'b00;
      end
    end
  end

`ifdef WEST_FEEDER_STALL_CNT_EN
  logic        w_accept, w_stalled;
  logic [15:0] r_stall_cnt;

  assign w_accept  = (r_state == S_IDLE) && ((cmd_load && !r_kl) || (!cmd_load && cmd_exec));
  assign w_stalled = ((r_state == S_LOAD) || (r_state == S_EXEC)) && r_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      r_stall_cnt <= '0;
    else if (w_accept)                              r_stall_cnt <= '0;
    else if (w_stalled && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign full          = r_full;
  assign empty         = r_empty;
  assign out_e         = r_out_e;
  assign inst_e        = r_inst_e;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign kernel_loaded = r_kl;
  assign err           = r_err;

endmodule
